branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, in-flight prediction queue entries (power of two, 2..8).
REQ-002 SHALL provide parameter IDX_W, default 7, predictor PHT index width.
REQ-003 SHALL provide parameter UPD_DEPTH, default 2, predictor-update buffer entries.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 push_valid  in  1  decode-stage branch carrying a prediction enters the queue.
REQ-007 push_taken  in  1  predicted direction.
REQ-008 push_index  in  IDX_W  PHT index used for the prediction.
REQ-009 push_target  in  32  predicted taken target.
REQ-010 push_fallthru  in  32  not-taken PC (branch PC + 8).
REQ-011 res_valid  in  1  memory-stage branch outcome available; res_ready  out  1  outcome accepted this cycle.
REQ-012 res_taken  in  1  actual direction; res_target  in  32  actual taken target.
REQ-013 redirect_valid  out  1  one-cycle redirect/flush pulse; redirect_pc  out  32  corrected fetch PC.
REQ-014 upd_valid  out  1; upd_ready  in  1; upd_index  out  IDX_W; upd_taken  out  1; upd_mispredict  out  1 -- predictor update channel, valid/ready.
REQ-015 q_full  out  1; q_empty  out  1; err_overflow  out  1 sticky; err_underflow  out  1 sticky.

Function
REQ-016 Queue SHALL be FIFO ordered; head = oldest unresolved branch.
REQ-017 Push SHALL occur when push_valid & !q_full & state==RUN; push_valid while q_full SHALL drop the entry and set err_overflow.
REQ-018 res_ready SHALL be 1 only when state==RUN and update buffer not full (combinational).
REQ-019 Accepted resolution (res_valid & res_ready) with q_empty SHALL set err_underflow and have no other effect.
REQ-020 Accepted resolution with entry SHALL pop head; mispredict = (res_taken != head.taken) | (res_taken & res_target != head.target).
REQ-021 Push and non-mispredicting pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-022 Mispredicting pop SHALL clear the whole queue at that edge, including any same-cycle push (younger path).
REQ-023 Every accepted non-underflow resolution SHALL write {head.index, res_taken, mispredict} into the update buffer at that edge.
REQ-024 FSM states RUN, RECOVER: RUN->RECOVER on mispredicting pop; RECOVER->RUN unconditionally after one cycle.
REQ-025 redirect_valid SHALL be 1 exactly during the RECOVER cycle; redirect_pc = res_target if res_taken else head.fallthru, registered at the mispredict edge; redirect_pc holds last value otherwise.
REQ-026 In RECOVER, pushes SHALL be ignored (no overflow flag) and res_ready SHALL be 0.
REQ-027 Update buffer SHALL be FIFO; upd_valid = non-empty; entry removed on upd_valid & upd_ready; upd_* fields stable while upd_valid & !upd_ready.
REQ-028 Update write and read in the same cycle SHALL both occur; resolution-to-upd_valid latency 1 cycle when buffer empty.
REQ-029 Pointers SHALL wrap modulo DEPTH/UPD_DEPTH; full/empty from occupancy counter of width clog2(depth)+1.

Reset
REQ-030 rst SHALL empty both queues, state=RUN, redirect_valid=0, redirect_pc=0, upd_valid=0, q_empty=1, q_full=0, error flags=0.
REQ-031 rst SHALL override all concurrent push, resolution and update handshakes, including mid-RECOVER.
REQ-032 Error flags SHALL clear only on rst.

Verification
REQ-033 Push 4 entries (taken, target 0x100..0x130), 5th push -> q_full=1, 5th dropped, err_overflow=1.
REQ-034 Head taken/0x100, resolve taken/0x100 -> no redirect; next cycle upd_valid=1, upd_mispredict=0.
REQ-035 Head taken/0x100, fallthru 0x48, resolve not-taken with same-cycle push -> next cycle redirect_valid=1, redirect_pc=0x48, q_empty=1, push lost, res_ready=0; following cycle state RUN.
REQ-036 Head not-taken, resolve taken/0x200 -> redirect_pc=0x200, upd_taken=1, upd_mispredict=1.
REQ-037 upd_ready=0, two correct resolutions -> res_ready=0, upd fields stable; raise upd_ready -> two updates drain in order, res_ready returns 1.
REQ-038 Resolve on empty queue -> err_underflow=1, no upd_valid; assert rst during RECOVER -> redirect_valid=0 next cycle, all flags 0.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Branch resolve unit bus: prediction push, outcome resolution, redirect,
// predictor-update channel and queue status flags.
// master = pipeline side driving the unit, slave = branch_resolve_unit itself.
interface branch_resolve_unit_if #(
  parameter int IDX_W = 7
);
  // Decode-stage prediction push
  logic             push_valid;
  logic             push_taken;
  logic [IDX_W-1:0] push_index;
  logic [31:0]      push_target;
  logic [31:0]      push_fallthru;

  // Memory-stage resolution
  logic             res_valid;
  logic             res_ready;
  logic             res_taken;
  logic [31:0]      res_target;

  // Fetch redirect
  logic             redirect_valid;
  logic [31:0]      redirect_pc;

  // Predictor update channel
  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic             upd_mispredict;

  // Status
  logic             q_full;
  logic             q_empty;
  logic             err_overflow;
  logic             err_underflow;

  modport master (
    output push_valid, push_taken, push_index, push_target, push_fallthru,
    output res_valid, res_taken, res_target,
    output upd_ready,
    input  res_ready,
    input  redirect_valid, redirect_pc,
    input  upd_valid, upd_index, upd_taken, upd_mispredict,
    input  q_full, q_empty, err_overflow, err_underflow
  );

  modport slave (
    input  push_valid, push_taken, push_index, push_target, push_fallthru,
    input  res_valid, res_taken, res_target,
    input  upd_ready,
    output res_ready,
    output redirect_valid, redirect_pc,
    output upd_valid, upd_index, upd_taken, upd_mispredict,
    output q_full, q_empty, err_overflow, err_underflow
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: keeps in-flight predictions in FIFO order, checks each
// memory-stage outcome against the oldest prediction, flushes and redirects
// fetch on a mispredict, and buffers predictor-update records for the PHT.
module branch_resolve_unit #(
  parameter int DEPTH     = 4,
  parameter int IDX_W     = 7,
  parameter int UPD_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int UPTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int UCNT_W = $clog2(UPD_DEPTH) + 1;
  // Prediction entry layout: {taken, index, target, fallthru}
  localparam int ENT_W  = 1 + IDX_W + 32 + 32;
  // Update record layout: {index, taken, mispredict}
  localparam int UPD_W  = IDX_W + 2;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_t             state_reg;
  state_t             state_next;

  logic [ENT_W-1:0]   q_mem [DEPTH];
  logic [PTR_W-1:0]   q_wr_ptr_reg;
  logic [PTR_W-1:0]   q_rd_ptr_reg;
  logic [CNT_W-1:0]   q_count_reg;

  logic [UPD_W-1:0]   upd_mem [UPD_DEPTH];
  logic [UPTR_W-1:0]  upd_wr_ptr_reg;
  logic [UPTR_W-1:0]  upd_rd_ptr_reg;
  logic [UCNT_W-1:0]  upd_count_reg;

  logic [31:0]        redirect_pc_reg;
  logic               err_overflow_reg;
  logic               err_underflow_reg;

  // ------------------------------------------------------------------
  // Control decode
  // ------------------------------------------------------------------
  logic               in_run;
  logic               q_full;
  logic               q_empty;
  logic               upd_full;
  logic               upd_nonempty;
  logic               res_ready;
  logic               res_fire;
  logic               push_en;
  logic               push_drop;
  logic               pop;
  logic               underflow;
  logic               mispredict;
  logic               flush;
  logic               upd_wr;
  logic               upd_rd;
  logic               redirect_valid;

  logic               head_taken;
  logic [IDX_W-1:0]   head_index;
  logic [31:0]        head_target;
  logic [31:0]        head_fallthru;
  logic [UPD_W-1:0]   upd_head;

  assign in_run       = (state_reg == RUN);
  assign q_full       = (q_count_reg == CNT_W'(DEPTH));
  assign q_empty      = (q_count_reg == '0);
  assign upd_full     = (upd_count_reg == UCNT_W'(UPD_DEPTH));
  assign upd_nonempty = (upd_count_reg != '0);

  // Oldest unresolved prediction, read straight from the head slot
  assign {head_taken, head_index, head_target, head_fallthru} = q_mem[q_rd_ptr_reg];
  assign upd_head = upd_mem[upd_rd_ptr_reg];

  // Resolution handshake and queue operation decode for this cycle
  always_comb begin
    res_ready  = in_run && !upd_full;
    res_fire   = bus.res_valid && res_ready;
    underflow  = res_fire && q_empty;
    pop        = res_fire && !q_empty;
    // Pushes are only considered while running; in RECOVER they vanish
    push_en    = bus.push_valid && in_run && !q_full;
    push_drop  = bus.push_valid && in_run && q_full;
    mispredict = (bus.res_taken != head_taken) ||
                 (bus.res_taken && (bus.res_target != head_target));
    flush      = pop && mispredict;
    upd_wr     = pop;
    upd_rd     = upd_nonempty && bus.upd_ready;
  end

  // ------------------------------------------------------------------
  // FSM: one RECOVER cycle after every mispredicting pop
  // ------------------------------------------------------------------

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and redirect strobe
  always_comb begin
    state_next     = state_reg;
    redirect_valid = 1'b0;
    case (state_reg)
      RUN: begin
        if (flush) begin
          state_next = RECOVER;
        end
      end
      RECOVER: begin
        redirect_valid = 1'b1;
        state_next     = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Prediction queue storage: one slot per entry, loaded by write pointer
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_q_entry
      logic [ENT_W-1:0] entry_reg;

      // Capture the pushed prediction when this slot is the write target
      always_ff @(posedge clk) begin
        if (push_en && (q_wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= {bus.push_taken, bus.push_index,
                        bus.push_target, bus.push_fallthru};
        end
      end

      assign q_mem[gi] = entry_reg;
    end
  endgenerate

  // Queue pointers and occupancy; a mispredict discards everything,
  // including a prediction pushed in the same cycle (it is on the wrong path)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_wr_ptr_reg <= '0;
      q_rd_ptr_reg <= '0;
      q_count_reg  <= '0;
    end else begin
      if (push_en) begin
        q_wr_ptr_reg <= (q_wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : q_wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        q_rd_ptr_reg <= (q_rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : q_rd_ptr_reg + 1'b1;
      end
      case ({push_en, pop})
        2'b10:   q_count_reg <= q_count_reg + 1'b1;
        2'b01:   q_count_reg <= q_count_reg - 1'b1;
        default: q_count_reg <= q_count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Predictor-update buffer
  // ------------------------------------------------------------------
  generate
    for (gi = 0; gi < UPD_DEPTH; gi++) begin : g_upd_entry
      logic [UPD_W-1:0] rec_reg;

      // Record the resolved branch outcome when this slot is the write target
      always_ff @(posedge clk) begin
        if (upd_wr && (upd_wr_ptr_reg == UPTR_W'(gi))) begin
          rec_reg <= {head_index, bus.res_taken, mispredict};
        end
      end

      assign upd_mem[gi] = rec_reg;
    end
  endgenerate

  // Update buffer pointers and occupancy; write and drain may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_wr_ptr_reg <= '0;
      upd_rd_ptr_reg <= '0;
      upd_count_reg  <= '0;
    end else begin
      if (upd_wr) begin
        upd_wr_ptr_reg <= (upd_wr_ptr_reg == UPTR_W'(UPD_DEPTH - 1)) ? '0 : upd_wr_ptr_reg + 1'b1;
      end
      if (upd_rd) begin
        upd_rd_ptr_reg <= (upd_rd_ptr_reg == UPTR_W'(UPD_DEPTH - 1)) ? '0 : upd_rd_ptr_reg + 1'b1;
      end
      case ({upd_wr, upd_rd})
        2'b10:   upd_count_reg <= upd_count_reg + 1'b1;
        2'b01:   upd_count_reg <= upd_count_reg - 1'b1;
        default: upd_count_reg <= upd_count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Redirect target and sticky error flags
  // ------------------------------------------------------------------

  // Corrected fetch PC captured at the mispredict edge, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_reg <= '0;
    end else if (flush) begin
      redirect_pc_reg <= bus.res_taken ? bus.res_target : head_fallthru;
    end
  end

  // Error flags latch on the offending event and clear only on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      if (push_drop) begin
        err_overflow_reg <= 1'b1;
      end
      if (underflow) begin
        err_underflow_reg <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.res_ready      = res_ready;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc_reg;
  assign bus.upd_valid      = upd_nonempty;
  assign bus.upd_index      = upd_head[UPD_W-1:2];
  assign bus.upd_taken      = upd_head[1];
  assign bus.upd_mispredict = upd_head[0];
  assign bus.q_full         = q_full;
  assign bus.q_empty        = q_empty;
  assign bus.err_overflow   = err_overflow_reg;
  assign bus.err_underflow  = err_underflow_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a reference model tracks the
// prediction queue; expected update records are queued when resolutions are
// driven and compared as the DUT presents them on the update channel.
module tb_branch_resolve_unit;

  localparam int DEPTH     = 4;
  localparam int IDX_W     = 7;
  localparam int UPD_DEPTH = 2;

  typedef struct {
    bit               taken;
    logic [IDX_W-1:0] idx;
    logic [31:0]      tgt;
    logic [31:0]      ft;
  } pred_t;

  logic clk;
  logic rst;

  branch_resolve_unit_if #(.IDX_W(IDX_W)) bus ();

  branch_resolve_unit #(
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .UPD_DEPTH(UPD_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  pred_t              mq[$];
  logic [IDX_W+1:0]   sb_upd[$];
  bit                 m_recover;
  logic [31:0]        m_redirect_pc;
  bit                 m_err_ovf;
  bit                 m_err_unf;

  int tests_run;
  int tests_failed;

  // Stimulus for the next cycle
  bit               d_rst;
  bit               d_pv;
  bit               d_pt;
  logic [IDX_W-1:0] d_pi;
  logic [31:0]      d_ptg;
  logic [31:0]      d_pft;
  bit               d_rv;
  bit               d_rt;
  logic [31:0]      d_rtg;
  bit               d_ur;

  task automatic check_equal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb_upd.delete();
    m_recover     = 1'b0;
    m_redirect_pc = '0;
    m_err_ovf     = 1'b0;
    m_err_unf     = 1'b0;
  endtask

  // One clock cycle: drive, check outputs at negedge, advance model, step edge
  task automatic step();
    pred_t h;
    pred_t p;
    bit    acc;
    bit    push_ok;
    bit    mis;
    bit    nrec;
    bus.push_valid    = d_pv;
    bus.push_taken    = d_pt;
    bus.push_index    = d_pi;
    bus.push_target   = d_ptg;
    bus.push_fallthru = d_pft;
    bus.res_valid     = d_rv;
    bus.res_taken     = d_rt;
    bus.res_target    = d_rtg;
    bus.upd_ready     = d_ur;
    rst               = d_rst;
    @(negedge clk);
    check_equal("q_empty", 64'(bus.q_empty), 64'(mq.size() == 0));
    check_equal("q_full", 64'(bus.q_full), 64'(mq.size() == DEPTH));
    check_equal("res_ready", 64'(bus.res_ready), 64'(!m_recover && sb_upd.size() < UPD_DEPTH));
    check_equal("redirect_valid", 64'(bus.redirect_valid), 64'(m_recover));
    check_equal("redirect_pc", 64'(bus.redirect_pc), 64'(m_redirect_pc));
    check_equal("err_overflow", 64'(bus.err_overflow), 64'(m_err_ovf));
    check_equal("err_underflow", 64'(bus.err_underflow), 64'(m_err_unf));
    check_equal("upd_valid", 64'(bus.upd_valid), 64'(sb_upd.size() != 0));
    if (sb_upd.size() != 0) begin
      check_equal("upd_fields", 64'({bus.upd_index, bus.upd_taken, bus.upd_mispredict}),
                  64'(sb_upd[0]));
    end
    if (d_rst) begin
      model_reset();
    end else begin
      acc     = d_rv && !m_recover && (sb_upd.size() < UPD_DEPTH);
      push_ok = d_pv && !m_recover && (mq.size() < DEPTH);
      if (d_pv && !m_recover && mq.size() == DEPTH) m_err_ovf = 1'b1;
      if (sb_upd.size() != 0 && d_ur) void'(sb_upd.pop_front());
      nrec = 1'b0;
      if (acc && mq.size() == 0) begin
        m_err_unf = 1'b1;
      end else if (acc) begin
        h   = mq.pop_front();
        mis = (d_rt != h.taken) || (d_rt && (d_rtg != h.tgt));
        sb_upd.push_back({h.idx, d_rt, mis});
        if (mis) begin
          m_redirect_pc = d_rt ? d_rtg : h.ft;
          nrec          = 1'b1;
        end
      end
      if (push_ok) begin
        p.taken = d_pt;
        p.idx   = d_pi;
        p.tgt   = d_ptg;
        p.ft    = d_pft;
        mq.push_back(p);
      end
      if (nrec) mq.delete();
      m_recover = nrec;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_drive();
    d_rst = 0; d_pv = 0; d_pt = 0; d_pi = '0; d_ptg = '0; d_pft = '0;
    d_rv = 0; d_rt = 0; d_rtg = '0; d_ur = 1;
  endtask

  task automatic set_push(input bit t, input int idx, input logic [31:0] tgt, input logic [31:0] ft);
    d_pv = 1; d_pt = t; d_pi = IDX_W'(idx); d_ptg = tgt; d_pft = ft;
  endtask

  task automatic set_res(input bit t, input logic [31:0] tgt);
    d_rv = 1; d_rt = t; d_rtg = tgt;
  endtask

  task automatic do_reset();
    clear_drive();
    d_rst = 1;
    step();
    clear_drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_drive();
    bus.push_valid = 0; bus.push_taken = 0; bus.push_index = '0;
    bus.push_target = '0; bus.push_fallthru = '0;
    bus.res_valid = 0; bus.res_taken = 0; bus.res_target = '0; bus.upd_ready = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step();  // reset state

    // Fill the queue, then a fifth push is dropped and flags overflow
    for (int i = 0; i < 5; i++) begin
      clear_drive();
      set_push(1'b1, i + 1, 32'h100 + 32'(i * 16), 32'h48 + 32'(i * 16));
      step();
    end
    clear_drive();
    step();

    // Correct taken resolution: no redirect, clean update next cycle
    set_res(1'b1, 32'h100);
    step();
    clear_drive();
    step();

    // Push and correct pop together keep occupancy
    set_push(1'b0, 9, 32'h500, 32'h508);
    set_res(1'b1, 32'h110);
    step();
    clear_drive();
    step();

    // Head taken/0x100 fallthru 0x48; not-taken outcome with same-cycle push
    do_reset();
    set_push(1'b1, 3, 32'h100, 32'h48);
    step();
    clear_drive();
    set_res(1'b0, 32'h0);
    set_push(1'b1, 4, 32'h140, 32'h88);
    step();
    clear_drive();
    set_push(1'b1, 6, 32'h150, 32'h98);  // ignored during RECOVER
    set_res(1'b1, 32'h150);              // not accepted during RECOVER
    step();
    clear_drive();
    step();

    // Head not-taken, resolved taken to 0x200
    set_push(1'b0, 5, 32'h180, 32'h60);
    step();
    clear_drive();
    set_res(1'b1, 32'h200);
    step();
    clear_drive();
    step();
    step();

    // Taken with wrong target, then correct not-taken
    set_push(1'b1, 12, 32'h300, 32'h70);
    step();
    clear_drive();
    set_res(1'b1, 32'h304);
    step();
    clear_drive();
    step();
    set_push(1'b0, 13, 32'h400, 32'h78);
    step();
    clear_drive();
    set_res(1'b0, 32'h0);
    step();
    clear_drive();
    step();

    // Update back-pressure: buffer fills, res_ready drops, drain in order
    for (int i = 0; i < 3; i++) begin
      clear_drive();
      d_ur = 0;
      set_push(1'b1, 20 + i, 32'h600 + 32'(i * 4), 32'h700);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      clear_drive();
      d_ur = 0;
      set_res(1'b1, 32'h600 + 32'(i * 4));
      step();
    end
    clear_drive();
    d_ur = 0;
    step();
    clear_drive();
    repeat (4) step();
    set_res(1'b1, 32'h608);
    step();
    clear_drive();
    step();

    // Underflow on empty queue, then reset in the middle of RECOVER
    do_reset();
    set_res(1'b1, 32'h10);
    step();
    clear_drive();
    step();
    set_push(1'b1, 30, 32'h800, 32'h808);
    step();
    clear_drive();
    set_res(1'b0, 32'h0);
    step();
    clear_drive();
    d_rst = 1;
    set_push(1'b1, 31, 32'h900, 32'h908);
    step();
    clear_drive();
    step();
    step();

    // Randomised traffic with small target sets so mispredicts are frequent
    for (int i = 0; i < 150; i++) begin
      clear_drive();
      d_pv  = ($urandom_range(0, 2) != 0);
      d_pt  = $urandom_range(0, 1) != 0;
      d_pi  = IDX_W'($urandom_range(0, 127));
      d_ptg = 32'h1000 + 32'($urandom_range(0, 1) * 4);
      d_pft = 32'h2000 + 32'($urandom_range(0, 15) * 8);
      d_rv  = ($urandom_range(0, 1) != 0);
      d_rt  = ($urandom_range(0, 3) != 0);
      d_rtg = 32'h1000 + 32'($urandom_range(0, 3) == 0 ? 4 : 0);
      d_ur  = ($urandom_range(0, 3) != 0);
      d_rst = ($urandom_range(0, 63) == 0);
      step();
    end
    clear_drive();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
